// File: rtl/morse_text_buffer_if.sv
// Decoder-to-text-generator bus for morse_text_buffer.
// The master drives the letter/done/rd_addr inputs, and the slave (the buffer) drives the status and read data.
interface morse_text_buffer_if #(
    parameter int ADDR_W = 5
);
    logic [7:0]        letter;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              busy;
    logic              overflow;

    modport master (
        output letter, done, rd_addr,
        input  rd_data, count, full, busy, overflow
    );

    modport slave (
        input  letter, done, rd_addr,
        output rd_data, count, full, busy, overflow
    );
endinterface

// File: rtl/morse_text_buffer.sv
// Line buffer between the Morse decoder and the VGA text generator.
// When MORSE_BUF_SCROLL_EN is defined, a full line scrolls left; otherwise the letter is dropped and overflow is set.
module morse_text_buffer #(
    parameter int         DEPTH    = 32,
    parameter int         ADDR_W   = 5,
    parameter logic [7:0] BS_CODE  = 8'h08,
    parameter logic [7:0] CLR_CODE = 8'h0C,
    parameter logic [7:0] BLANK    = 8'h20
) (
    input logic                clk,
    input logic                reset,
    morse_text_buffer_if.slave bus
);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       DEPTH_U  = DEPTH;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [ADDR_W:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];

    logic             evt;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] bs_idx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            clr_idx_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= BLANK;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            mem_q      <= mem_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        done_d     = bus.done;
        mem_d      = mem_q;
        evt        = bus.done & ~done_q;
        wr_idx     = count_q[IDX_W-1:0];
        bs_idx     = IDX_W'(count_q - CNT_ONE);

        // Reads see the pre-write array, so a same-cycle write to the same index returns old data.
        if ({1'b0, bus.rd_addr} < DEPTH_C) begin
            rd_data_d = mem_q[bus.rd_addr[IDX_W-1:0]];
        end else begin
            rd_data_d = BLANK;
        end

        case (state_q)
            ST_CLEAR: begin
                mem_d[clr_idx_q] = BLANK;
                count_d          = '0;
                if (evt && (bus.letter == CLR_CODE)) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == LAST_IDX) begin
                    clr_idx_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + IDX_ONE;
                end
            end

            ST_IDLE: begin
                if (evt) begin
                    if (bus.letter == CLR_CODE) begin
                        state_d    = ST_CLEAR;
                        clr_idx_d  = '0;
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end else if (bus.letter == BS_CODE) begin
                        if (count_q != '0) begin
                            count_d       = count_q - CNT_ONE;
                            mem_d[bs_idx] = BLANK;
                        end
                    end else if (count_q < DEPTH_C) begin
                        mem_d[wr_idx] = bus.letter;
                        count_d       = count_q + CNT_ONE;
                    end else begin
`ifdef MORSE_BUF_SCROLL_EN
                        for (int unsigned i = 0; i + 1 < DEPTH_U; i++) begin
                            mem_d[IDX_W'(i)] = mem_q[IDX_W'(i + 1)];
                        end
                        mem_d[LAST_IDX] = bus.letter;
`else
                        overflow_d = 1'b1;
`endif
                    end
                end
            end

            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.count    = count_q;
    assign bus.full     = (count_q == DEPTH_C);
    assign bus.busy     = (state_q == ST_CLEAR);
    assign bus.overflow = overflow_q;

endmodule
